serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/digit_adder.sv | 30 +++
 rtl/serial_adder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the digit-serial add/subtract unit.
// Contents: state_t FSM encoding, cnt_width() digit-counter sizing helper.
// Imported by serial_adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Digit counter must be at least one bit wide, even when a single digit
  // covers the whole word.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// digit_adder: combinational DIGIT-bit ripple-carry adder slice.
// Ports: x, y operand digits; ci carry in; s digit sum; co carry out of top bit;
//        cMsb carry into the top bit (used for signed-overflow detection).
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cMsb
);

  logic [DIGIT:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co   = c[DIGIT];
  assign cMsb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: WIDTH-bit add/subtract, DIGIT bits per cycle, LSB digit first.
// Latency: outValid rises WIDTH/DIGIT cycles after the accepting edge.
// Backpressure: result held in DONE until outReady; inReady only in IDLE.
// Ports: clk, rstN (async active-low); inValid/inReady, a, b, cIn, sub operand side;
//        outValid/outReady, sum, cOut result side; busy = RUN or DONE.
// Optional: define SERIAL_ADDER_OVF_EN to add output ovf (signed overflow flag).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cIn,
  input  logic             sub,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] sum,
  output logic             cOut,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("serial_adder: DIGIT must be >= 1 and divide WIDTH exactly");
  end

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt;
  logic            carry;
  logic            cout_reg;
  logic            accept;
  logic            last;

  logic [DIGIT-1:0] d_sum;
  logic             d_co;
  logic             d_cmsb;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x    (a_reg[DIGIT-1:0]),
    .y    (b_reg[DIGIT-1:0]),
    .ci   (carry),
    .s    (d_sum),
    .co   (d_co),
    .cMsb (d_cmsb)
  );

  assign accept = inValid && (state == IDLE);
  assign last   = (cnt == CW'(N - 1));
  // New digit enters at the MSB end; after N shifts the word is in place.
  assign res_nxt = WIDTH'({d_sum, res_reg} >> DIGIT);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = RUN;
      RUN:     if (last)     state_nxt = DONE;
      DONE:    if (outReady) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      carry    <= 1'b0;
      cout_reg <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Subtract as a + ~b + ~borrow_in.
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= cIn ^ sub;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_reg   <= a_reg >> DIGIT;
          b_reg   <= b_reg >> DIGIT;
          carry   <= d_co;
          res_reg <= res_nxt;
          cnt     <= cnt + CW'(1);
          if (last) cout_reg <= d_co;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_reg;
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovf_reg <= 1'b0;
    end else if (state == RUN && last) begin
      ovf_reg <= d_cmsb ^ d_co;
    end
  end
  assign ovf = ovf_reg;
`else
  logic cmsb_unused;
  assign cmsb_unused = d_cmsb;
`endif

  assign inReady  = (state == IDLE);
  assign outValid = (state == DONE);
  assign busy     = (state != IDLE);
  assign sum      = res_reg;
  assign cOut     = cout_reg;

endmodule
